skeleton_counter_bank: RTL
==========================

# skeleton_counter_bank

Parametrised bank of `NUM_CH` independent `CW`-bit counters, the successor to the single free-running debug counter in the FPGA skeleton top. Each channel has a programmable terminal value and a wrap, saturate or one-shot mode. Each channel produces a terminal-count pulse and sticky status. It sits in the `clk` domain behind the `IBUFGDS`/`BUFG` clock path and drives heartbeat, timeout and debug-probe logic.

## Interface
- `NUM_CH`, 4, number of channels (1..16)
- `CW`, 32, counter width in bits (2..64)
- `CHW`, `$clog2(NUM_CH)` with a minimum of 1, channel-index width (derived; not overridden)

- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  reset, synchronous and active-high
- `cfg_we`  in  1  configuration write strobe, one cycle
- `cfg_ch`  in  CHW  channel written; index ≥ `NUM_CH` is ignored
- `cfg_mode`  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- `cfg_limit`  in  CW  terminal value
- `cnt_en`  in  NUM_CH  per-channel count enable (level)
- `cnt_clr`  in  NUM_CH  per-channel clear (level, sampled each cycle)
- `count`  out  NUM_CH*CW  channel i occupies bits `[i*CW +: CW]`
- `tc_pulse`  out  NUM_CH  one-cycle terminal-count pulse
- `done`  out  NUM_CH  channel halted (saturated or one-shot complete)
- `ovf`  out  NUM_CH  sticky: wrap occurred since last clear

## Operation
- Per channel FSM:
  - RUN: counting allowed.
  - HOLD: count frozen, `done`=1.
- Terminal condition: `count >= limit` (not equality), evaluated on the current registered `limit`.
- Step, in RUN with `cnt_en`=1:
  - Not terminal: `count` <= `count`+1.
  - Terminal, wrap mode: `count` <= 0, `tc_pulse`=1, `ovf` set; stays RUN.
  - Terminal, saturate mode: `count` <= `limit`, `tc_pulse`=1; go to HOLD.
  - Terminal, one-shot mode: `count` <= 0, `tc_pulse`=1; go to HOLD.
- HOLD: ignores `cnt_en`; only `cnt_clr` or `rst` returns the channel to RUN.
- `cnt_clr` on a channel:
  - `count` <= 0, `done` <= 0, `ovf` <= 0, state RUN, `tc_pulse`=0.
  - Wins over a same-cycle step.
- `cfg_we`:
  - Updates `limit` and `mode` of channel `cfg_ch` on the next edge.
  - Does not touch `count`, `done`, `ovf` or the FSM state.
  - A step in the same cycle uses the old limit and old mode.
  - `cfg_we` and `cnt_clr` on the same channel in the same cycle both take effect.
- Limit lowered below the current count:
  - The next enabled step is terminal.
  - In wrap mode that step wraps to 0.
- `limit`=0, wrap mode: every enabled cycle pulses `tc_pulse`; `count` stays 0.
- No carry out of `CW` bits is possible, because the terminal check fires at or before all-ones.

## Timing
- All outputs are registered; `count`, `tc_pulse`, `done` and `ovf` update on the same edge.
- `tc_pulse` is high for exactly the one cycle in which `count` shows the post-terminal value.
- Latency:
  - Enable to first increment visible: 1 cycle.
  - `cnt_clr` to `count`=0: 1 cycle.
  - `cfg_we` to new limit in effect: the step one cycle after the write.
- Reset values, applied on the edge with `rst`=1:
  - `count`=0, `tc_pulse`=0, `done`=0, `ovf`=0.
  - State RUN, `limit`=all ones, mode wrap.
- `rst` mid-count aborts all channels identically; pending `cfg_we` in the same cycle is dropped.
- Continuous `cnt_en` with `limit`=L in wrap mode: period L+1 cycles, `tc_pulse` duty 1/(L+1).

## Structure
- Shared package `FPGA_skeleton_PKG` holds:
  - `typedef enum logic [1:0] {CM_WRAP, CM_SAT, CM_ONESHOT, CM_RSVD} cnt_mode_t`.
  - `typedef enum logic {CS_RUN, CS_HOLD} cnt_state_t`.
  - Default parameter constants `CNT_NUM_CH_DEF`=4 and `CNT_CW_DEF`=32.
- Sub-module `skeleton_counter_ch`:
  - One channel: limit/mode registers, FSM, counter and status flags.
  - Ports: `clk`, `rst`, `cfg_we`, `cfg_mode`, `cfg_limit`, `cnt_en`, `cnt_clr` in; `count`, `tc_pulse`, `done`, `ovf` out.
- `skeleton_counter_bank`:
  - Decodes `cfg_ch` to per-channel write enables.
  - Instantiates `NUM_CH` channels in a generate loop and packs the outputs.
- `count` carries `mark_debug` for ILA capture.

## Test plan
- Reset, then wrap mode with limit=3 and `cnt_en` high → `count` 0,1,2,3,0,…; `tc_pulse` on every 4th cycle, aligned with `count`=0; `ovf`=1 after the first wrap.
- Saturate mode, limit=5, enable held → `count` reaches 5 and stays; one `tc_pulse`; `done`=1. Then `cnt_clr` for 1 cycle → `count`=0, `done`=0, counting resumes.
- One-shot mode, limit=2 → `count` 0,1,2,0 then frozen; a single `tc_pulse`; `done`=1; further `cnt_en` has no effect.
- Channel 0 at `count`=10 in wrap mode, `cfg_we` sets limit=4 → next enabled step wraps to 0 with `tc_pulse`. Separately, `cfg_we` and a step in the same cycle → the step obeys the old limit.
- `cnt_clr` and `cnt_en` asserted together at `count`=limit → `count`=0, `tc_pulse`=0, `ovf` cleared. Then `rst` mid-run on all channels → all outputs at reset values next cycle and limit=all ones.
- `NUM_CH`=1, `CW`=2, limit=0, wrap mode → `tc_pulse` every enabled cycle. `cfg_ch` out of range with `NUM_CH`=3 → no channel changes.

Source files
------------

// File: rtl/FPGA_skeleton_PKG.sv
// Shared types and defaults for the skeleton counter bank.
// Mode and state encodings are used by both the channel and the bank wrapper.
package FPGA_skeleton_PKG;

   typedef enum logic [1:0] {
      CM_WRAP    = 2'b00,
      CM_SAT     = 2'b01,
      CM_ONESHOT = 2'b10,
      CM_RSVD    = 2'b11
   } cnt_mode_t;

   typedef enum logic {
      CS_RUN  = 1'b0,
      CS_HOLD = 1'b1
   } cnt_state_t;

   localparam int CNT_NUM_CH_DEF = 4;
   localparam int CNT_CW_DEF     = 32;

   // Channel-index width, never narrower than one bit.
   function automatic int chw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/skeleton_counter_ch.sv
// One counter channel: limit/mode registers, RUN/HOLD FSM, counter and status flags.
// All outputs come straight from flops; done is the HOLD state itself.
module skeleton_counter_ch
   import FPGA_skeleton_PKG::*;
#(
   parameter int CW = CNT_CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_mode,
   input  logic [CW-1:0] cfg_limit,
   input  logic          cnt_en,
   input  logic          cnt_clr,
   output logic [CW-1:0] count,
   output logic          tc_pulse,
   output logic          done,
   output logic          ovf,
   output cnt_state_t    state
);

   (* mark_debug = "true" *) logic [CW-1:0] r_count;
   logic [CW-1:0] r_limit;
   cnt_mode_t     r_mode;
   cnt_state_t    r_state;
   logic          r_tc;
   logic          r_ovf;

   logic [CW-1:0] w_count_nxt;
   cnt_state_t    w_state_nxt;
   logic          w_tc_nxt;
   logic          w_ovf_nxt;
   logic          w_terminal;

   // Magnitude compare so a limit lowered below the count still terminates.
   assign w_terminal = (r_count >= r_limit);

   always_comb begin
      w_count_nxt = r_count;
      w_state_nxt = r_state;
      w_tc_nxt    = 1'b0;
      w_ovf_nxt   = r_ovf;
      if (cnt_clr) begin
         w_count_nxt = '0;
         w_state_nxt = CS_RUN;
         w_ovf_nxt   = 1'b0;
      end else if ((r_state == CS_RUN) && cnt_en) begin
         if (!w_terminal) begin
            w_count_nxt = r_count + CW'(1);
         end else begin
            w_tc_nxt = 1'b1;
            case (r_mode)
               CM_SAT: begin
                  w_count_nxt = r_limit;
                  w_state_nxt = CS_HOLD;
               end
               CM_ONESHOT: begin
                  w_count_nxt = '0;
                  w_state_nxt = CS_HOLD;
               end
               default: begin
                  w_count_nxt = '0;
                  w_ovf_nxt   = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_state <= CS_RUN;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
         r_limit <= '1;
         r_mode  <= CM_WRAP;
      end else begin
         r_count <= w_count_nxt;
         r_state <= w_state_nxt;
         r_tc    <= w_tc_nxt;
         r_ovf   <= w_ovf_nxt;
         // Config lands after this edge's step, which therefore used the old values.
         if (cfg_we) begin
            r_limit <= cfg_limit;
            r_mode  <= cnt_mode_t'(cfg_mode);
         end
      end
   end

   assign count    = r_count;
   assign tc_pulse = r_tc;
   assign done     = (r_state == CS_HOLD);
   assign ovf      = r_ovf;
   assign state    = r_state;

endmodule

// File: rtl/skeleton_counter_bank.sv
// Bank of NUM_CH independent counters with per-channel config decode and packed outputs.
// dbg_state exposes each channel's RUN(0)/HOLD(1) state for probing.
module skeleton_counter_bank
   import FPGA_skeleton_PKG::*;
#(
   parameter int NUM_CH = CNT_NUM_CH_DEF,
   parameter int CW     = CNT_CW_DEF,
   parameter int CHW    = chw_of(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [CHW-1:0]       cfg_ch,
   input  logic [1:0]           cfg_mode,
   input  logic [CW-1:0]        cfg_limit,
   input  logic [NUM_CH-1:0]    cnt_en,
   input  logic [NUM_CH-1:0]    cnt_clr,
   (* mark_debug = "true" *)
   output logic [NUM_CH*CW-1:0] count,
   output logic [NUM_CH-1:0]    tc_pulse,
   output logic [NUM_CH-1:0]    done,
   output logic [NUM_CH-1:0]    ovf,
   output logic [NUM_CH-1:0]    dbg_state
);

   logic [NUM_CH-1:0] w_ch_we;
   cnt_state_t        w_state [NUM_CH];

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         // Indices at or above NUM_CH match no channel and are dropped.
         assign w_ch_we[i]   = cfg_we && (cfg_ch == CHW'(i));
         assign dbg_state[i] = w_state[i];

         skeleton_counter_ch #(
            .CW (CW)
         ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cfg_we    (w_ch_we[i]),
            .cfg_mode  (cfg_mode),
            .cfg_limit (cfg_limit),
            .cnt_en    (cnt_en[i]),
            .cnt_clr   (cnt_clr[i]),
            .count     (count[i*CW +: CW]),
            .tc_pulse  (tc_pulse[i]),
            .done      (done[i]),
            .ovf       (ovf[i]),
            .state     (w_state[i])
         );
      end
   endgenerate

endmodule
